// File: rtl/multiport_regfile.sv
// Multi-port architectural register file: combinational bypassed reads,
// prioritised synchronous writes and a per-register busy scoreboard.
module multiport_regfile #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 4,
   parameter int NUM_WR   = 2
) (
   input  logic                       clk,
   input  logic                       Reset,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
   input  logic [NUM_WR*DATA_W-1:0]   wr_data,
   input  logic [NUM_WR-1:0]          alloc_en,
   input  logic [NUM_WR*ADDR_W-1:0]   alloc_addr,
   input  logic                       flush
);

   localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUM_REGS);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;

   logic [ADDR_W-1:0]   wa [NUM_WR];
   logic [ADDR_W-1:0]   aa [NUM_WR];
   logic [DATA_W-1:0]   wd [NUM_WR];
   logic [ADDR_W-1:0]   ra [NUM_RD];
   logic [NUM_WR-1:0]   wr_ok;
   logic [NUM_WR-1:0]   alloc_ok;
   logic [NUM_REGS-1:0] wr_hit;
   logic [NUM_REGS-1:0] alloc_hit;

   // Register 0 and addresses past the end of the file are never real targets.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a != '0) && ({1'b0, a} < NREG);
   endfunction

   always_comb begin
      wr_hit    = '0;
      alloc_hit = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         wa[p]       = wr_addr[p*ADDR_W +: ADDR_W];
         aa[p]       = alloc_addr[p*ADDR_W +: ADDR_W];
         wd[p]       = wr_data[p*DATA_W +: DATA_W];
         wr_ok[p]    = wr_en[p] && !Reset && addr_ok(wa[p]);
         alloc_ok[p] = alloc_en[p] && !Reset && addr_ok(aa[p]);
         if (wr_ok[p])
            wr_hit[wa[p]] = 1'b1;
         if (alloc_ok[p])
            alloc_hit[aa[p]] = 1'b1;
      end
   end

   // Later ports overwrite earlier ones, so the youngest write wins a conflict.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs[r] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++)
            if (wr_ok[p])
               regs[wa[p]] <= wd[p];
      end
   end

   // An allocation beats a same-cycle writeback: the new producer owns the register.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset)
         busy <= '0;
      else if (flush)
         busy <= '0;
      else
         busy <= (busy & ~wr_hit) | alloc_hit;
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         ra[i] = rd_addr[i*ADDR_W +: ADDR_W];
         if (!Reset && addr_ok(ra[i])) begin
            rd_data[i*DATA_W +: DATA_W] = regs[ra[i]];
            rd_busy[i]                  = busy[ra[i]];
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_ok[p] && (wa[p] == ra[i])) begin
                  rd_data[i*DATA_W +: DATA_W] = wd[p];
                  rd_busy[i]                  = 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed self-checking bench for multiport_regfile (24 registers so the
// out-of-range address path is reachable).
module tb_multiport_regfile;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 4;
   localparam int NW = 2;

   logic              clk;
   logic              Reset;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_busy;
   logic [NW-1:0]     wr_en;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*DW-1:0]  wr_data;
   logic [NW-1:0]     alloc_en;
   logic [NW*AW-1:0]  alloc_addr;
   logic              flush;

   int vectors = 0;
   int errors  = 0;
   logic [DW-1:0] exp_q[$];

   multiport_regfile #(
      .DATA_W(DW), .NUM_REGS(24), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)
   ) dut (
      .clk(clk), .Reset(Reset),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // drivers
   task automatic idle();
      wr_en = '0; alloc_en = '0; flush = 1'b0;
      wr_addr = '0; wr_data = '0; alloc_addr = '0;
   endtask

   task automatic set_rd(input int i, input logic [AW-1:0] a);
      rd_addr[i*AW +: AW] = a;
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_en[p] = 1'b1;
      wr_addr[p*AW +: AW] = a;
      wr_data[p*DW +: DW] = d;
   endtask

   task automatic alloc(input int p, input logic [AW-1:0] a);
      alloc_en[p] = 1'b1;
      alloc_addr[p*AW +: AW] = a;
   endtask

   function automatic logic [DW-1:0] rdd(input int i);
      return rd_data[i*DW +: DW];
   endfunction

   // advance past one rising edge; inputs change only at the falling edge
   task automatic next_cycle();
      @(negedge clk);
      idle();
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      rd_addr = '0;
      idle();
      @(negedge clk);
      #1;
      set_rd(0, 5'd5);
      check("reset_data", rdd(0), 32'h0);
      check("reset_busy", {28'h0, rd_busy}, 32'h0);
      Reset = 1'b0;
      #1;

      // write R5 and allocate R6, then pulse Reset between edges
      wr(0, 5'd5, 32'hDEADBEEF);
      alloc(1, 5'd6);
      next_cycle();
      set_rd(1, 5'd6);
      #1;
      check("r5_stored", rdd(0), 32'hDEADBEEF);
      check("r6_busy", {31'h0, rd_busy[1]}, 32'h1);
      wr(0, 5'd7, 32'hCAFE0007);
      set_rd(2, 5'd7);
      Reset = 1'b1;
      #1;
      check("rst_r5_data", rdd(0), 32'h0);
      check("rst_bypass_off", rdd(2), 32'h0);
      check("rst_busy_all", {28'h0, rd_busy}, 32'h0);
      idle();
      #1;
      Reset = 1'b0;
      #1;
      check("post_rst_r5", rdd(0), 32'h0);
      check("post_rst_r6_busy", {31'h0, rd_busy[1]}, 32'h0);
      next_cycle();
      check("pending_write_lost", rdd(2), 32'h0);

      // bypass on port 0
      wr(0, 5'd7, 32'h12345678);
      set_rd(0, 5'd7);
      #1;
      check("bypass_same_cycle", rdd(0), 32'h12345678);
      next_cycle();
      check("bypass_stored", rdd(0), 32'h12345678);

      // write conflict: port 1 wins
      wr(0, 5'd9, 32'h1);
      wr(1, 5'd9, 32'h2);
      set_rd(1, 5'd9);
      #1;
      check("conflict_bypass", rdd(1), 32'h2);
      next_cycle();
      check("conflict_stored", rdd(1), 32'h2);

      // register 0 ignores writes and allocations
      wr(0, 5'd0, 32'hFFFFFFFF);
      wr(1, 5'd0, 32'hFFFFFFFF);
      alloc(0, 5'd0);
      alloc(1, 5'd0);
      set_rd(0, 5'd0);
      #1;
      check("r0_data_pre", rdd(0), 32'h0);
      check("r0_busy_pre", {31'h0, rd_busy[0]}, 32'h0);
      next_cycle();
      check("r0_data_post", rdd(0), 32'h0);
      check("r0_busy_post", {31'h0, rd_busy[0]}, 32'h0);

      // out-of-range address 25 behaves like nothing is there
      wr(1, 5'd25, 32'hA5A5A5A5);
      alloc(0, 5'd25);
      set_rd(3, 5'd25);
      #1;
      check("oor_bypass", rdd(3), 32'h0);
      next_cycle();
      check("oor_data", rdd(3), 32'h0);
      check("oor_busy", {31'h0, rd_busy[3]}, 32'h0);

      // scoreboard: alloc R3 at N, busy at N+1, writeback at N+2
      alloc(0, 5'd3);
      set_rd(2, 5'd3);
      #1;
      check("alloc_not_same_cycle", {31'h0, rd_busy[2]}, 32'h0);
      next_cycle();
      check("alloc_busy_next", {31'h0, rd_busy[2]}, 32'h1);
      next_cycle();
      check("busy_holds", {31'h0, rd_busy[2]}, 32'h1);
      wr(1, 5'd3, 32'hAA);
      #1;
      check("wb_busy_comb", {31'h0, rd_busy[2]}, 32'h0);
      check("wb_data_comb", rdd(2), 32'hAA);
      next_cycle();
      check("wb_busy_after", {31'h0, rd_busy[2]}, 32'h0);
      check("wb_data_after", rdd(2), 32'hAA);

      // alloc and write of R4 together: allocation wins
      alloc(0, 5'd4);
      wr(1, 5'd4, 32'h44);
      set_rd(3, 5'd4);
      #1;
      check("r4_wr_busy_comb", {31'h0, rd_busy[3]}, 32'h0);
      next_cycle();
      check("r4_alloc_wins", {31'h0, rd_busy[3]}, 32'h1);
      check("r4_data", rdd(3), 32'h44);

      // flush
      alloc(0, 5'd1);
      alloc(1, 5'd2);
      next_cycle();
      alloc(0, 5'd3);
      set_rd(0, 5'd1);
      set_rd(1, 5'd2);
      set_rd(2, 5'd3);
      next_cycle();
      check("pre_flush_busy", {28'h0, rd_busy}, 32'hF);
      flush = 1'b1;
      alloc(0, 5'd6);
      wr(1, 5'd8, 32'h55);
      next_cycle();
      check("flush_busy_r1_r4", {28'h0, rd_busy}, 32'h0);
      set_rd(0, 5'd6);
      set_rd(1, 5'd8);
      #1;
      check("flush_r6_busy", {31'h0, rd_busy[0]}, 32'h0);
      check("flush_r8_busy", {31'h0, rd_busy[1]}, 32'h0);
      check("flush_r8_data", rdd(1), 32'h55);

      // back-to-back writes R10..R13 read back in order
      for (int k = 0; k < 4; k++) begin
         wr(k % 2, AW'(10 + k), 32'h1000_0000 + 32'(k * 17));
         exp_q.push_back(32'h1000_0000 + 32'(k * 17));
         next_cycle();
      end
      for (int k = 0; k < 4; k++) begin
         set_rd(k, AW'(10 + k));
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         check("readback", rdd(k), exp_q.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised architectural register file for the 2-way superscalar datapath. It provides NUM_RD asynchronous read ports, NUM_WR synchronous write ports with same-cycle write-through bypass and deterministic write-conflict priority, and a per-register busy scoreboard. Issue sets a busy bit, writeback clears it, and flush clears all busy bits. It sits between decode/issue (reads, allocation) and writeback (writes). It replaces the single-write, two-read register file.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero
- ADDR_W, 5, register address width; requires 2^ADDR_W >= NUM_REGS
- NUM_RD, 4, read ports (2 per issue slot)
- NUM_WR, 2, write ports and allocation ports (1 per slot)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high; clears all registers and busy bits
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational, bypassed
- rd_busy  out  NUM_RD  busy status of each read address, combinational
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- alloc_en  in  NUM_WR  set busy bit of alloc_addr (destination reserved at issue)
- alloc_addr  in  NUM_WR*ADDR_W  allocation addresses
- flush  in  1  synchronous clear of all busy bits

## Operation
- Storage: NUM_REGS x DATA_W array plus a NUM_REGS-bit busy vector.
- Register 0 rules:
  - Writes and allocations to address 0 are discarded.
  - Reading address 0 returns 0 with busy 0.
- Addresses >= NUM_REGS:
  - Writes and allocations are discarded.
  - Reads return 0 with busy 0.
- Write priority: if several enabled write ports target the same address in one cycle, the highest-index port wins. Port NUM_WR-1 is the younger instruction.
- Read bypass: if any enabled write port targets rd_addr[i] this cycle, rd_data[i] = that port's wr_data (same priority). Otherwise rd_data[i] = the stored value.
- rd_busy[i] = busy[rd_addr[i]] AND NOT (any enabled write to rd_addr[i] this cycle). Allocations do not affect rd_busy in the cycle they are presented.
- Busy update at each clock edge, per register r, in priority order:
  1. flush: busy[r] = 0. All same-cycle allocations are dropped.
  2. Any alloc port targets r: busy[r] = 1. This includes a same-cycle write to r, because the new producer wins.
  3. Any write port targets r: busy[r] = 0.
  4. Otherwise busy[r] holds.
- Writes commit regardless of flush.
- While Reset is high:
  - Writes and allocations are ignored.
  - Bypass is suppressed.
  - All rd_data = 0 and all rd_busy = 0.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency: data is visible via bypass in the same cycle and from storage from the next cycle.
- Busy set: visible on rd_busy in the cycle after alloc_en.
- Busy clear: visible combinationally in the write cycle and held cleared thereafter.
- Reset:
  - Assertion clears the array and busy vector immediately, without waiting for clk.
  - On deassertion, the first rising edge may perform writes and allocations.
- Reset asserted mid-cycle while writes are pending: the pending writes are lost.

## Test plan
- Reset:
  - Write R5=0xDEADBEEF, then pulse Reset between edges.
  - Expect rd_data for R5 = 0 immediately and rd_busy = 0 on all ports.
- Bypass:
  - wr_en=01, wr_addr0=7, wr_data0=0x12345678, rd_addr0=7 in the same cycle.
  - Expect rd_data0 = 0x12345678 that cycle and from storage the next cycle.
- Write conflict:
  - Both ports write R9 (port0 = 0x1, port1 = 0x2) with rd_addr1=9.
  - Expect bypass 0x2 and stored 0x2 after the edge.
- Register 0:
  - wr_en=11 and alloc_en=11 all targeting R0 with data 0xFFFFFFFF.
  - Expect rd_data = 0 and rd_busy = 0 for R0 before and after the edge.
- Scoreboard:
  - alloc R3 at cycle N; rd_busy for R3 = 1 at N+1.
  - Write R3=0xAA at N+2: rd_busy = 0 during N+2, and R3 reads 0xAA.
  - At cycle M, alloc and write R4 together: expect busy(R4) = 1 after the edge.
- Flush:
  - Allocate R1, R2, R3, then assert flush together with alloc R6 and write R8=0x55.
  - After the edge: all busy bits = 0, R6 not busy, R8 = 0x55.
